// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - core/DMA arbiter for a shared data memory with a one-cycle registered response
// Core wins by default; a DMA requester that keeps losing is forced through after STARVE_LIMIT cycles.
module dmem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        c_req,
  input  logic        c_we,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  input  logic [2:0]  c_funct3,
  output logic        c_gnt,
  output logic        c_rvalid,
  output logic [31:0] c_rdata,
  output logic        c_err,

  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_funct3,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,

  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_din,
  output logic [2:0]  m_funct3,
  input  logic [31:0] m_dout
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE,
    RESP_C,
    RESP_D
  } resp_state_t;

  resp_state_t   state, state_next;
  logic [CW-1:0] starve_cnt;
  logic          starved;
  logic          any_gnt;

  logic          sel_we;
  logic [31:0]   sel_addr;
  logic [31:0]   sel_wdata;
  logic [2:0]    sel_funct3;
  logic          acc_illegal;
  logic [31:0]   resp_data;

  logic          resp_err_q;
  logic [31:0]   c_rdata_q;
  logic [31:0]   d_rdata_q;

  function automatic logic access_illegal(input logic we, input logic [2:0] f3,
                                          input logic [1:0] lsb);
    logic bad;
    bad = 1'b0;
    if (f3 == 3'b010 && lsb != 2'b00) bad = 1'b1;
    if ((f3 == 3'b001 || f3 == 3'b101) && lsb[0]) bad = 1'b1;
    if (we && !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010)) bad = 1'b1;
    if (!we && (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111)) bad = 1'b1;
    return bad;
  endfunction

  // Grants depend only on current requests and the registered starvation count.
  assign starved = (starve_cnt == CW'(STARVE_LIMIT));
  assign d_gnt   = !rst && d_req && (!c_req || starved);
  assign c_gnt   = !rst && c_req && !d_gnt;
  assign any_gnt = c_gnt || d_gnt;

  always_comb begin
    sel_we     = 1'b0;
    sel_addr   = 32'h0;
    sel_wdata  = 32'h0;
    sel_funct3 = 3'b000;
    if (c_gnt) begin
      sel_we     = c_we;
      sel_addr   = c_addr;
      sel_wdata  = c_wdata;
      sel_funct3 = c_funct3;
    end else if (d_gnt) begin
      sel_we     = d_we;
      sel_addr   = d_addr;
      sel_wdata  = d_wdata;
      sel_funct3 = d_funct3;
    end
  end

  assign acc_illegal = any_gnt && access_illegal(sel_we, sel_funct3, sel_addr[1:0]);
  assign m_we        = sel_we && !acc_illegal;
  assign m_addr      = sel_addr;
  assign m_din       = sel_wdata;
  assign m_funct3    = sel_funct3;

  // Stores and faulting accesses return zero data.
  assign resp_data = (acc_illegal || sel_we) ? 32'h0 : m_dout;

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!d_req || d_gnt) begin
      starve_cnt <= '0;
    end else if (!starved) begin
      starve_cnt <= starve_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = IDLE;
    if (c_gnt) begin
      state_next = RESP_C;
    end else if (d_gnt) begin
      state_next = RESP_D;
    end
  end

  // Per-port data registers so each port's rdata holds until its own next response.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_err_q <= 1'b0;
      c_rdata_q  <= 32'h0;
      d_rdata_q  <= 32'h0;
    end else begin
      if (any_gnt) resp_err_q <= acc_illegal;
      if (c_gnt)   c_rdata_q  <= resp_data;
      if (d_gnt)   d_rdata_q  <= resp_data;
    end
  end

  // Outputs are also gated by rst so the reset state is visible in the reset cycle itself.
  assign c_rvalid = !rst && (state == RESP_C);
  assign d_rvalid = !rst && (state == RESP_D);
  assign c_err    = c_rvalid && resp_err_q;
  assign d_err    = d_rvalid && resp_err_q;
  assign c_rdata  = rst ? 32'h0 : c_rdata_q;
  assign d_rdata  = rst ? 32'h0 : d_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
// Directed vector table, hand sequences for starvation and reset, then random traffic against a model.
module tb_dmem_arbiter;

  localparam int STARVE = 4;
  localparam logic [31:0] Z = 32'h0;

  logic        clk;
  logic        rst;
  logic        c_req, c_we, c_gnt, c_rvalid, c_err;
  logic [31:0] c_addr, c_wdata, c_rdata;
  logic [2:0]  c_funct3;
  logic        d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [2:0]  d_funct3;
  logic        m_we;
  logic [31:0] m_addr, m_din, m_dout;
  logic [2:0]  m_funct3;

  dmem_arbiter #(.STARVE_LIMIT(STARVE)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_funct3(c_funct3),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_err(c_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_funct3(d_funct3),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .m_we(m_we), .m_addr(m_addr), .m_din(m_din), .m_funct3(m_funct3), .m_dout(m_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        creq, cwe;
    logic [31:0] caddr, cwd;
    logic [2:0]  cf3;
    logic        dreq, dwe;
    logic [31:0] daddr, dwd;
    logic [2:0]  df3;
    logic [31:0] mdout;
    logic        cgnt, dgnt, mwe;
    logic [31:0] maddr;
    logic        crv;
    logic [31:0] crd;
    logic        cerr, drv;
    logic [31:0] drd;
    logic        derr;
  } vec_t;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst;
    c_req = v.creq; c_we = v.cwe; c_addr = v.caddr; c_wdata = v.cwd; c_funct3 = v.cf3;
    d_req = v.dreq; d_we = v.dwe; d_addr = v.daddr; d_wdata = v.dwd; d_funct3 = v.df3;
    m_dout = v.mdout;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic is_illegal(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    int a;
    a = int'(addr[7:0]);
    if (f3 == 3'd2 && a % 4 != 0) return 1'b1;
    if ((f3 == 3'd1 || f3 == 3'd5) && a % 2 != 0) return 1'b1;
    if (we && f3 > 3'd2) return 1'b1;
    if (!we && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 1'b1;
    return 1'b0;
  endfunction

  vec_t tbl[11];
  vec_t v;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit prev_c, prev_d, exp_d;
    int k;
    int losses, pend;
    logic pend_err;
    logic [31:0] c_hold, d_hold, data;
    logic win_c, win_d, ill, gwe;
    logic [31:0] gaddr, gwd;
    logic [2:0] gf3;

    // rst, creq,cwe,caddr,cwd,cf3, dreq,dwe,daddr,dwd,df3, mdout, cgnt,dgnt,mwe,maddr, crv,crd,cerr, drv,drd,derr
    tbl[0]  = '{1'b1, 1'b1,1'b0,Z,Z,3'd2, 1'b1,1'b0,Z,Z,3'd2, Z,
                1'b0,1'b0,1'b0,Z, 1'b0,Z,1'b0, 1'b0,Z,1'b0};
    tbl[1]  = '{1'b0, 1'b1,1'b1,32'h10,32'hDEADBEEF,3'd2, 1'b0,1'b0,Z,Z,3'd0, Z,
                1'b1,1'b0,1'b1,32'h10, 1'b0,Z,1'b0, 1'b0,Z,1'b0};
    tbl[2]  = '{1'b0, 1'b0,1'b0,Z,Z,3'd0, 1'b0,1'b0,Z,Z,3'd0, Z,
                1'b0,1'b0,1'b0,Z, 1'b1,Z,1'b0, 1'b0,Z,1'b0};
    tbl[3]  = '{1'b0, 1'b0,1'b0,Z,Z,3'd0, 1'b1,1'b0,32'h12,Z,3'd2, 32'h12345678,
                1'b0,1'b1,1'b0,32'h12, 1'b0,Z,1'b0, 1'b0,Z,1'b0};
    tbl[4]  = '{1'b0, 1'b1,1'b1,32'h13,32'h0000ABCD,3'd1, 1'b0,1'b0,Z,Z,3'd0, Z,
                1'b1,1'b0,1'b0,32'h13, 1'b0,Z,1'b0, 1'b1,Z,1'b1};
    tbl[5]  = '{1'b0, 1'b0,1'b0,Z,Z,3'd0, 1'b0,1'b0,Z,Z,3'd0, Z,
                1'b0,1'b0,1'b0,Z, 1'b1,Z,1'b1, 1'b0,Z,1'b0};
    tbl[6]  = '{1'b0, 1'b1,1'b0,32'h80,Z,3'd0, 1'b0,1'b0,Z,Z,3'd0, 32'hFFFFFF7F,
                1'b1,1'b0,1'b0,32'h80, 1'b0,Z,1'b0, 1'b0,Z,1'b0};
    tbl[7]  = '{1'b0, 1'b0,1'b0,Z,Z,3'd0, 1'b1,1'b0,32'h81,Z,3'd4, 32'h000000FF,
                1'b0,1'b1,1'b0,32'h81, 1'b1,32'hFFFFFF7F,1'b0, 1'b0,Z,1'b0};
    tbl[8]  = '{1'b0, 1'b0,1'b0,Z,Z,3'd0, 1'b0,1'b0,Z,Z,3'd0, Z,
                1'b0,1'b0,1'b0,Z, 1'b0,32'hFFFFFF7F,1'b0, 1'b1,32'h000000FF,1'b0};
    tbl[9]  = '{1'b0, 1'b0,1'b0,Z,Z,3'd0, 1'b0,1'b0,Z,Z,3'd0, Z,
                1'b0,1'b0,1'b0,Z, 1'b0,32'hFFFFFF7F,1'b0, 1'b0,32'h000000FF,1'b0};
    tbl[10] = '{1'b1, 1'b1,1'b0,32'h40,Z,3'd2, 1'b0,1'b0,Z,Z,3'd0, 32'h55555555,
                1'b0,1'b0,1'b0,Z, 1'b0,Z,1'b0, 1'b0,Z,1'b0};

    v = tbl[0];
    drive(v);
    @(negedge clk);

    foreach (tbl[i]) begin
      drive(tbl[i]);
      #1;
      check($sformatf("vec%0d_gnt", i), 32'({c_gnt, d_gnt}), 32'({tbl[i].cgnt, tbl[i].dgnt}));
      check($sformatf("vec%0d_mwe", i), 32'(m_we), 32'(tbl[i].mwe));
      check($sformatf("vec%0d_maddr", i), m_addr, tbl[i].maddr);
      check($sformatf("vec%0d_c_rsp", i), 32'({c_rvalid, c_err}), 32'({tbl[i].crv, tbl[i].cerr}));
      check($sformatf("vec%0d_c_rdata", i), c_rdata, tbl[i].crd);
      check($sformatf("vec%0d_d_rsp", i), 32'({d_rvalid, d_err}), 32'({tbl[i].drv, tbl[i].derr}));
      check($sformatf("vec%0d_d_rdata", i), d_rdata, tbl[i].drd);
      next_cycle();
    end

    // Both ports requesting continuously: C,C,C,C,D repeating, rvalid one cycle behind.
    prev_c = 1'b0;
    prev_d = 1'b0;
    for (int i = 0; i < 15; i++) begin
      v = tbl[2];
      v.creq = 1'b1; v.caddr = 32'(i * 4); v.cf3 = 3'd2;
      v.dreq = 1'b1; v.daddr = 32'(256 + i * 4); v.df3 = 3'd2;
      drive(v);
      #1;
      exp_d = (i % 5 == 4);
      check($sformatf("starve%0d_gnt", i), 32'({c_gnt, d_gnt}), 32'({!exp_d, exp_d}));
      check($sformatf("starve%0d_rv", i), 32'({c_rvalid, d_rvalid}), 32'({prev_c, prev_d}));
      prev_c = !exp_d;
      prev_d = exp_d;
      next_cycle();
    end

    // Reset right after a core accept with a part-filled starvation count.
    for (int i = 0; i < 9; i++) begin
      v = tbl[2];
      v.rst = (i == 3);
      v.creq = 1'b1; v.caddr = 32'h20; v.cf3 = 3'd2;
      v.dreq = 1'b1; v.daddr = 32'h24; v.df3 = 3'd2;
      drive(v);
      #1;
      if (i == 3) begin
        check("rst_gnt", 32'({c_gnt, d_gnt}), 32'h0);
        check("rst_rv", 32'({c_rvalid, d_rvalid}), 32'h0);
        check("rst_rdata", c_rdata, Z);
        prev_c = 1'b0;
        prev_d = 1'b0;
      end else begin
        k = (i < 3) ? i : i - 4;
        exp_d = (k == 4);
        check($sformatf("rstseq%0d_gnt", i), 32'({c_gnt, d_gnt}), 32'({!exp_d, exp_d}));
        check($sformatf("rstseq%0d_rv", i), 32'({c_rvalid, d_rvalid}), 32'({prev_c, prev_d}));
        prev_c = !exp_d;
        prev_d = exp_d;
      end
      next_cycle();
    end

    // Random traffic against a behavioural model.
    losses = 0; pend = 0; pend_err = 1'b0; c_hold = Z; d_hold = Z;
    for (int n = 0; n < 400; n++) begin
      v = tbl[2];
      v.rst   = (n == 0) || ($urandom_range(0, 24) == 0);
      v.creq  = ($urandom_range(0, 9) < 7);
      v.cwe   = 1'($urandom_range(0, 1));
      v.caddr = $urandom;
      v.cwd   = $urandom;
      v.cf3   = 3'($urandom_range(0, 7));
      v.dreq  = ($urandom_range(0, 9) < 7);
      v.dwe   = 1'($urandom_range(0, 1));
      v.daddr = $urandom;
      v.dwd   = $urandom;
      v.df3   = 3'($urandom_range(0, 7));
      v.mdout = $urandom;
      drive(v);
      #1;

      win_d = !v.rst && v.dreq && (!v.creq || losses >= STARVE);
      win_c = !v.rst && v.creq && !win_d;
      gwe = 1'b0; gaddr = Z; gwd = Z; gf3 = 3'd0;
      if (win_c) begin gwe = v.cwe; gaddr = v.caddr; gwd = v.cwd; gf3 = v.cf3; end
      if (win_d) begin gwe = v.dwe; gaddr = v.daddr; gwd = v.dwd; gf3 = v.df3; end
      ill = (win_c || win_d) && is_illegal(gwe, gf3, gaddr);

      check($sformatf("rnd%0d_gnt", n), 32'({c_gnt, d_gnt}), 32'({win_c, win_d}));
      check($sformatf("rnd%0d_mctl", n), 32'({m_we, m_funct3}), 32'({gwe && !ill, gf3}));
      check($sformatf("rnd%0d_maddr", n), m_addr, gaddr);
      check($sformatf("rnd%0d_mdin", n), m_din, gwd);
      if (v.rst) begin
        check($sformatf("rnd%0d_rsp", n), 32'({c_rvalid, c_err, d_rvalid, d_err}), 32'h0);
        check($sformatf("rnd%0d_rdata", n), c_rdata | d_rdata, Z);
      end else begin
        check($sformatf("rnd%0d_rsp", n), 32'({c_rvalid, c_err, d_rvalid, d_err}),
              32'({pend == 1, pend == 1 && pend_err, pend == 2, pend == 2 && pend_err}));
        check($sformatf("rnd%0d_c_rdata", n), c_rdata, c_hold);
        check($sformatf("rnd%0d_d_rdata", n), d_rdata, d_hold);
      end

      if (v.rst) begin
        losses = 0; pend = 0; pend_err = 1'b0; c_hold = Z; d_hold = Z;
      end else begin
        if (!v.dreq || win_d) losses = 0;
        else losses++;
        data = (ill || gwe) ? Z : v.mdout;
        pend = win_c ? 1 : (win_d ? 2 : 0);
        pend_err = ill;
        if (win_c) c_hold = data;
        if (win_d) d_hold = data;
      end
      next_cycle();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
